// File: rtl/operand_fetch.sv
// operand_fetch: read-side initiator for the 2R/1W register file.
// Accepts decoded instructions, drives the register file read addresses,
// tracks in-flight writes in a busy scoreboard, stalls on RAW/WAW hazards,
// optionally forwards same-cycle writeback data, and presents registered
// operands to execute one cycle after acceptance.
module operand_fetch #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_rd_we,
    output logic [4:0]  rf_rd_addr0,
    output logic [4:0]  rf_rd_addr1,
    input  logic [31:0] rf_rd_data0,
    input  logic [31:0] rf_rd_data1,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rs1_data,
    output logic [31:0] out_rs2_data,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic [31:0] busy
);

    logic        byp_rs1;
    logic        byp_rs2;
    logic        haz_rs1;
    logic        haz_rs2;
    logic        haz_waw;
    logic        accept;
    logic [31:0] op_rs1;
    logic [31:0] op_rs2;
    logic [31:0] busy_next;

    // The register file is read combinationally straight from the decoded sources.
    assign rf_rd_addr0 = in_rs1;
    assign rf_rd_addr1 = in_rs2;

    // Hazard detection and handshake: a source is blocked while its writer is
    // in flight unless the value is being written back (and forwarded) now.
    always_comb begin
        byp_rs1  = BYPASS && wb_valid && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
        byp_rs2  = BYPASS && wb_valid && (wb_rd == in_rs2) && (in_rs2 != 5'd0);
        haz_rs1  = (in_rs1 != 5'd0) && busy[in_rs1] && !byp_rs1;
        haz_rs2  = (in_rs2 != 5'd0) && busy[in_rs2] && !byp_rs2;
        haz_waw  = in_rd_we && (in_rd != 5'd0) && busy[in_rd]
                   && !(wb_valid && (wb_rd == in_rd));
        in_ready = (!out_valid || out_ready) && !haz_rs1 && !haz_rs2 && !haz_waw;
        accept   = in_valid && in_ready;
    end

    // Operand select: x0 reads as zero, forwarded writeback beats the stale file value.
    always_comb begin
        // NOTE: each output takes a default first so every path assigns it and no latch is inferred.
        op_rs1 = rf_rd_data0;
        op_rs2 = rf_rd_data1;
        if (in_rs1 == 5'd0) begin
            op_rs1 = 32'd0;
        end else if (byp_rs1) begin
            op_rs1 = wb_data;
        end
        if (in_rs2 == 5'd0) begin
            op_rs2 = 32'd0;
        end else if (byp_rs2) begin
            op_rs2 = wb_data;
        end
    end

    // Scoreboard update: clear on writeback first, then set on issue so a new
    // writer to the same register wins; x0 is never marked busy.
    always_comb begin
        busy_next = busy;
        if (wb_valid && (wb_rd != 5'd0)) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (accept && in_rd_we && (in_rd != 5'd0)) begin
            busy_next[in_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Output stage and scoreboard state: load on accept, drop valid on drain, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy         <= 32'd0;
            out_valid    <= 1'b0;
            out_rs1_data <= 32'd0;
            out_rs2_data <= 32'd0;
            out_rd       <= 5'd0;
            out_rd_we    <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples pre-edge values.
            busy <= busy_next;
            if (accept) begin
                out_valid    <= 1'b1;
                out_rs1_data <= op_rs1;
                out_rs2_data <= op_rs2;
                out_rd       <= in_rd;
                out_rd_we    <= in_rd_we;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: a BYPASS=1 instance checked through an
// expected-beat queue drained by an output monitor, plus a BYPASS=0 instance
// exercised with a short directed sequence.
module tb_operand_fetch;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    logic        clk;
    logic        rst;

    // BYPASS=1 instance signals
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [4:0]  rf_rd_addr0;
    logic [4:0]  rf_rd_addr1;
    logic [31:0] rf_rd_data0;
    logic [31:0] rf_rd_data1;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [31:0] busy;

    // BYPASS=0 instance signals
    logic        nb_in_valid;
    logic        nb_in_ready;
    logic [4:0]  nb_in_rs1;
    logic [4:0]  nb_in_rs2;
    logic [4:0]  nb_in_rd;
    logic        nb_in_rd_we;
    logic [4:0]  nb_rf_rd_addr0;
    logic [4:0]  nb_rf_rd_addr1;
    logic [31:0] nb_rf_rd_data0;
    logic [31:0] nb_rf_rd_data1;
    logic        nb_wb_valid;
    logic [4:0]  nb_wb_rd;
    logic [31:0] nb_wb_data;
    logic        nb_out_valid;
    logic        nb_out_ready;
    logic [31:0] nb_out_rs1_data;
    logic [31:0] nb_out_rs2_data;
    logic [4:0]  nb_out_rd;
    logic        nb_out_rd_we;
    logic [31:0] nb_busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    // Register file model: x0 holds garbage so the DUT must force it to zero.
    logic [31:0] rf [32];

    operand_fetch #(.BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
        .rf_rd_addr0(rf_rd_addr0), .rf_rd_addr1(rf_rd_addr1),
        .rf_rd_data0(rf_rd_data0), .rf_rd_data1(rf_rd_data1),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .busy(busy)
    );

    operand_fetch #(.BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .in_valid(nb_in_valid), .in_ready(nb_in_ready),
        .in_rs1(nb_in_rs1), .in_rs2(nb_in_rs2), .in_rd(nb_in_rd), .in_rd_we(nb_in_rd_we),
        .rf_rd_addr0(nb_rf_rd_addr0), .rf_rd_addr1(nb_rf_rd_addr1),
        .rf_rd_data0(nb_rf_rd_data0), .rf_rd_data1(nb_rf_rd_data1),
        .wb_valid(nb_wb_valid), .wb_rd(nb_wb_rd), .wb_data(nb_wb_data),
        .out_valid(nb_out_valid), .out_ready(nb_out_ready),
        .out_rs1_data(nb_out_rs1_data), .out_rs2_data(nb_out_rs2_data),
        .out_rd(nb_out_rd), .out_rd_we(nb_out_rd_we), .busy(nb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: x[i] = 0x11*i after reset, written by writeback on the edge.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h11 * i;
            rf[0] <= 32'hBAD0BAD0;
        end else if (wb_valid && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
    end
    assign rf_rd_data0 = rf[rf_rd_addr0];
    assign rf_rd_data1 = rf[rf_rd_addr1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic we);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.rd = rd;
        e.we = we;
        return e;
    endfunction

    // Output monitor: every transfer to execute must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL out_beat: unexpected beat rs1=%h rs2=%h rd=%0d we=%0b",
                         out_rs1_data, out_rs2_data, out_rd, out_rd_we);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (out_rs1_data !== e.a || out_rs2_data !== e.b ||
                    out_rd !== e.rd || out_rd_we !== e.we) begin
                    n_bad++;
                    $display("FAIL out_beat: got rs1=%h rs2=%h rd=%0d we=%0b expected rs1=%h rs2=%h rd=%0d we=%0b",
                             out_rs1_data, out_rs2_data, out_rd, out_rd_we, e.a, e.b, e.rd, e.we);
                end
            end
        end
    end

    // Present an instruction (called just after a rising edge), wait bounded for acceptance.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input exp_t e);
        bit got;
        got      = 1'b0;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                got = 1'b1;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got in_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Current instruction must be accepted this cycle.
    task automatic expect_accept(input string name, input exp_t e);
        @(negedge clk);
        check(name, {31'd0, in_ready}, 32'd1);
        if (in_ready) sb.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;
        nb_in_valid = 1'b0; nb_in_rs1 = '0; nb_in_rs2 = '0; nb_in_rd = '0; nb_in_rd_we = 1'b0;
        nb_rf_rd_data0 = '0; nb_rf_rd_data1 = '0;
        nb_wb_valid = 1'b0; nb_wb_rd = '0; nb_wb_data = '0; nb_out_ready = 1'b1;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_rs1", out_rs1_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // BYPASS=0: writeback cycle still stalls, operand comes from the file next cycle
        step();
        nb_in_rs1 = 5'd1; nb_in_rs2 = 5'd2; nb_in_rd = 5'd3; nb_in_rd_we = 1'b1;
        nb_rf_rd_data0 = 32'h11; nb_rf_rd_data1 = 32'h22; nb_in_valid = 1'b1;
        @(negedge clk);
        check("nb_first_ready", {31'd0, nb_in_ready}, 32'd1);
        step();
        nb_in_valid = 1'b0;
        @(negedge clk);
        check("nb_first_rs1", nb_out_rs1_data, 32'h11);
        check("nb_busy_set", nb_busy, 32'h8);
        step();
        nb_in_rs1 = 5'd3; nb_in_rs2 = 5'd2; nb_in_rd = 5'd4; nb_in_rd_we = 1'b0;
        nb_rf_rd_data0 = 32'h33; nb_in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("nb_raw_stall", {31'd0, nb_in_ready}, 32'd0);
        end
        step();
        nb_wb_valid = 1'b1; nb_wb_rd = 5'd3; nb_wb_data = 32'hDEADBEEF;
        @(negedge clk);
        check("nb_wb_cycle_stall", {31'd0, nb_in_ready}, 32'd0);
        step();
        nb_wb_valid = 1'b0; nb_rf_rd_data0 = 32'hDEADBEEF;
        @(negedge clk);
        check("nb_after_wb_ready", {31'd0, nb_in_ready}, 32'd1);
        step();
        nb_in_valid = 1'b0;
        @(negedge clk);
        check("nb_rs1_from_rf", nb_out_rs1_data, 32'hDEADBEEF);
        check("nb_rs2", nb_out_rs2_data, 32'h22);
        check("nb_busy_clear", nb_busy, 32'd0);
        step();

        // First instruction, one-cycle latency, busy[3] set
        issue(5'd1, 5'd2, 5'd3, 1'b1, mk(32'h11, 32'h22, 5'd3, 1'b1));
        @(negedge clk);
        check("first_out_valid", {31'd0, out_valid}, 32'd1);
        check("first_busy", busy, 32'h8);
        step();

        // RAW stall on x3, released by a bypassed writeback
        in_rs1 = 5'd3; in_rs2 = 5'd0; in_rd = 5'd4; in_rd_we = 1'b1; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("raw_stall", {31'd0, in_ready}, 32'd0);
        end
        step();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        expect_accept("raw_bypass_ready", mk(32'hDEADBEEF, 32'd0, 5'd4, 1'b1));
        step();
        wb_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("raw_busy", busy, 32'h10);
        step();

        // Backpressure hold for 5 cycles, then 8 back-to-back instructions
        out_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd7, 1'b1, mk(32'h55, 32'h66, 5'd7, 1'b1));
        in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd0; in_rd_we = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_out_rs1", out_rs1_data, 32'h55);
        end
        step();
        out_ready = 1'b1;
        expect_accept("release_ready", mk(32'h11, 32'h22, 5'd0, 1'b0));
        for (int i = 0; i < 8; i++) begin
            step();
            in_rs1 = 5'(i + 8); in_rs2 = 5'(i + 16); in_rd = 5'd0; in_rd_we = 1'b0;
            expect_accept("stream_ready", mk(32'h11 * (i + 8), 32'h11 * (i + 16), 5'd0, 1'b0));
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_busy", busy, 32'h90);

        // Same-cycle set and clear of x5: set wins
        step();
        issue(5'd1, 5'd1, 5'd5, 1'b1, mk(32'h11, 32'h11, 5'd5, 1'b1));
        in_rs1 = 5'd2; in_rs2 = 5'd2; in_rd = 5'd5; in_rd_we = 1'b1; in_valid = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55550005;
        expect_accept("setclr_ready", mk(32'h22, 32'h22, 5'd5, 1'b1));
        step();
        wb_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("set_wins_busy", busy, 32'hB0);

        // WAW on x5 stalls until the next writeback to x5
        step();
        in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd5; in_rd_we = 1'b1; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("waw_stall", {31'd0, in_ready}, 32'd0);
        end
        step();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h00000555;
        expect_accept("waw_release", mk(32'h11, 32'h22, 5'd5, 1'b1));
        step();

        // Set x6 and clear x4 in the same cycle
        in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd6; in_rd_we = 1'b1; in_valid = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h44;
        expect_accept("diff_idx_ready", mk(32'h11, 32'h22, 5'd6, 1'b1));
        step();
        wb_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("diff_idx_busy", busy, 32'hE0);

        // Writeback to a non-busy register leaves the scoreboard alone
        step();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h99;
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        check("wb_nonbusy", busy, 32'hE0);

        // x0 sources read as zero (file holds garbage); rd=0 and wb_rd=0 ignored
        step();
        in_rs1 = 5'd0; in_rs2 = 5'd0; in_rd = 5'd0; in_rd_we = 1'b1; in_valid = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        expect_accept("x0_ready", mk(32'd0, 32'd0, 5'd0, 1'b1));
        step();
        wb_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("x0_busy", busy, 32'hE0);

        // Bypass on rs2 (x6 busy, written back this cycle)
        step();
        in_rs1 = 5'd9; in_rs2 = 5'd6; in_rd = 5'd0; in_rd_we = 1'b0; in_valid = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66660006;
        expect_accept("rs2_bypass_ready", mk(32'h99, 32'h66660006, 5'd0, 1'b0));
        step();
        wb_valid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rs2_bypass_busy", busy, 32'hA0);
        step();

        // Build busy=0xF0, hold an operand, then reset asynchronously mid-cycle
        issue(5'd1, 5'd2, 5'd4, 1'b1, mk(32'h11, 32'h22, 5'd4, 1'b1));
        issue(5'd1, 5'd2, 5'd6, 1'b1, mk(32'h11, 32'h22, 5'd6, 1'b1));
        @(negedge clk);
        check("pre_rst_busy", busy, 32'hF0);
        step();
        out_ready = 1'b0;
        issue(5'd1, 5'd2, 5'd0, 1'b0, mk(32'h11, 32'h22, 5'd0, 1'b0));
        check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_busy", busy, 32'd0);
        check("async_rst_out_rs1", out_rs1_data, 32'd0);
        sb.delete();
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side initiator for the 2-read/1-write register file.
- Accepts decoded instructions (rs1, rs2, rd) over a valid/ready handshake and drives the two register file read addresses.
- Tracks pending writes in a 32-bit busy scoreboard and stalls on RAW/WAW hazards; bypasses same-cycle writeback data.
- Presents registered operands to execute one cycle later over a valid/ready handshake.

Parameters:
BYPASS, 1, 1 = forward wb_data to operands on a same-cycle rs/wb_rd match; 0 = stall until the register file holds the value.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  decoded instruction valid
in_ready  output  1  instruction accepted when in_valid & in_ready
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_rd  input  5  destination register
in_rd_we  input  1  instruction will write rd
rf_rd_addr0  output  5  register file read address 0 (= in_rs1, combinational)
rf_rd_addr1  output  5  register file read address 1 (= in_rs2, combinational)
rf_rd_data0  input  32  register file read data 0 (combinational read)
rf_rd_data1  input  32  register file read data 1
wb_valid  input  1  writeback occurring this cycle (same cycle as register file wr_ena)
wb_rd  input  5  writeback register
wb_data  input  32  writeback value
out_valid  output  1  operands valid to execute
out_ready  input  1  execute accepts
out_rs1_data  output  32  operand 1
out_rs2_data  output  32  operand 2
out_rd  output  5  destination passed through
out_rd_we  output  1  write-enable passed through
busy  output  32  scoreboard, bit n = write to xn pending

Behaviour:
- Reset (rst low, async): busy=0, out_valid=0, out_rs1_data=0, out_rs2_data=0, out_rd=0, out_rd_we=0. Any in-flight operand is discarded. Any pending busy bits are lost.
- x0: busy[0] is always 0. Operands read from x0 are forced to 0. in_rd_we with in_rd=0 sets no busy bit. wb_valid with wb_rd=0 is ignored.
- Hazard per source s in {rs1, rs2}: s!=0 & busy[s] & !(BYPASS & wb_valid & wb_rd==s).
- WAW hazard: in_rd_we & in_rd!=0 & busy[in_rd] & !(wb_valid & wb_rd==in_rd).
- in_ready = (!out_valid | out_ready) & !hazard_rs1 & !hazard_rs2 & !hazard_waw.
  - in_ready is combinational from inputs and state; it does not depend on in_valid.
- Operand select: wb_data if BYPASS & wb_valid & wb_rd==s & s!=0; 0 if s==0; otherwise rf_rd_data.
- Accept (in_valid & in_ready): on the next edge, out_* load the selected operands, in_rd and in_rd_we; out_valid=1. Latency is exactly 1 cycle.
- Hold: out_valid & !out_ready keeps all out_* stable and in_ready=0.
- Drain: out_valid & out_ready & no accept → out_valid=0 next cycle. Data outputs hold their last value.
- Back-to-back: out_ready=1 with continuous hazard-free input gives one instruction per cycle.
- Scoreboard:
  - Accept with in_rd_we & in_rd!=0 sets busy[in_rd].
  - wb_valid & wb_rd!=0 clears busy[wb_rd].
  - Same-cycle set and clear of the same index: set wins (new writer issued).
  - Set and clear of different indices both apply.
- Writeback to a non-busy register clears nothing harmful; the bit stays 0.
- in_valid low: no state change other than drain and scoreboard clears.

Test Plan:
- Reset then idle: rst low 2 cycles → busy=0, out_valid=0, in_ready=1. Issue rs1=1, rs2=2 with rf data 0x11/0x22, rd=3, we=1 → next cycle out_rs1_data=0x11, out_rs2_data=0x22, out_rd=3, busy=0x8.
- RAW stall: with busy[3] set, present rs1=3 → in_ready=0 for 4 cycles. wb_valid, wb_rd=3, wb_data=0xDEADBEEF → same cycle in_ready=1; next cycle out_rs1_data=0xDEADBEEF, busy[3]=0.
- BYPASS=0 variant of the previous case: in_ready stays 0 during the wb cycle, goes 1 the cycle after. Operand = rf_rd_data0 (0xDEADBEEF).
- Backpressure: out_ready=0 with out_valid=1 → in_ready=0, outputs stable 5 cycles. out_ready=1 plus a new instruction → one instruction per cycle for 8 cycles.
- Simultaneous set/clear: busy[5]=1, accept rd=5 we=1 while wb_rd=5 → busy[5] remains 1. WAW: a new instruction with rd=5 stalls until the next wb to 5.
- x0 and reset mid-operation: rs1=0, rs2=0, rd=0, we=1 → operands 0, busy stays 0. Assert rst while out_valid=1 and busy=0xF0 → out_valid=0, busy=0 immediately (asynchronously).
